vr_stall_injector: RTL and testbench

Synthesizable single-entry valid-ready slice that inserts programmable or pseudo-random stalls between an upstream producer and a downstream consumer. It replaces bench-side random delay loops around iterative units (e.g. the vector FP square-root) with a reusable block, generalised to any data width and to independently controlled issue and gap delays. It sits between the stimulus driver and the DUT start port, or between the DUT finish port and the checker.

---
 rtl/vr_stall_injector.sv | 123 ++++++++++++
 tb/tb_vr_stall_injector.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vr_stall_injector.sv
// vr_stall_injector: single-entry valid-ready slice with programmable or LFSR-driven issue and gap stalls.
// Define VR_STALL_INJ_STATS_EN to build the txn_cnt_o / stall_cnt_o statistics counters.
module vr_stall_injector #(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned DLY_W     = 4,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic [1:0]        mode_i,
    input  logic [DLY_W-1:0]  issue_dly_i,
    input  logic [DLY_W-1:0]  gap_dly_i,
    input  logic              up_valid_i,
    output logic              up_ready_o,
    input  logic [DATA_W-1:0] up_data_i,
    output logic              dn_valid_o,
    input  logic              dn_ready_i,
    output logic [DATA_W-1:0] dn_data_o,
    output logic [31:0]       txn_cnt_o,
    output logic [31:0]       stall_cnt_o
);

    typedef enum logic [1:0] {IDLE, HOLD, SEND, GAP} state_t;

    // An all-zero Galois LFSR never leaves zero, so a zero seed is replaced.
    localparam logic [15:0]      SEED      = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [15:0]      LFSR_POLY = 16'hB400;
    localparam logic [DLY_W-1:0] CNT_ONE   = {{(DLY_W-1){1'b0}}, 1'b1};

    state_t            state, state_nxt;
    logic [DLY_W-1:0]  cnt, cnt_nxt;
    logic [15:0]       lfsr;
    logic [DLY_W-1:0]  issue_draw, gap_draw;
    logic              up_hs, dn_hs;

    assign up_ready_o = (state == IDLE) & ~flush_i;
    assign dn_valid_o = (state == SEND);
    assign up_hs      = up_valid_i & up_ready_o;
    assign dn_hs      = dn_valid_o & dn_ready_i;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first; a missing branch would infer a latch.
        issue_draw = '0;
        gap_draw   = '0;
        unique case (mode_i)
            2'b00: ;
            2'b01: begin
                issue_draw = issue_dly_i;
                gap_draw   = gap_dly_i;
            end
            default: begin
                issue_draw = lfsr[DLY_W-1:0] & issue_dly_i;
                gap_draw   = lfsr[2*DLY_W-1:DLY_W] & gap_dly_i;
            end
        endcase
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (flush_i) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            unique case (state)
                IDLE: if (up_hs) begin
                    state_nxt = (issue_draw == '0) ? SEND : HOLD;
                    cnt_nxt   = issue_draw;
                end
                HOLD: begin
                    cnt_nxt = cnt - CNT_ONE;
                    if (cnt == CNT_ONE) state_nxt = SEND;
                end
                SEND: if (dn_hs) begin
                    state_nxt = (gap_draw == '0) ? IDLE : GAP;
                    cnt_nxt   = gap_draw;
                end
                GAP: begin
                    cnt_nxt = cnt - CNT_ONE;
                    if (cnt == CNT_ONE) state_nxt = IDLE;
                end
            endcase
        end
    end

    // The LFSR free-runs through stalls and flushes so random delays stay decorrelated from traffic.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            lfsr      <= SEED;
            dn_data_o <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            lfsr  <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_POLY : 16'h0000);
            if (up_hs) dn_data_o <= up_data_i;
        end
    end

`ifdef VR_STALL_INJ_STATS_EN
    logic [31:0] txn_cnt, stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txn_cnt   <= '0;
            stall_cnt <= '0;
        end else begin
            if (dn_hs) txn_cnt <= txn_cnt + 32'd1;
            if ((state == HOLD) || (state == GAP)) stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign txn_cnt_o   = txn_cnt;
    assign stall_cnt_o = stall_cnt;
`else
    assign txn_cnt_o   = 32'h0;
    assign stall_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_vr_stall_injector.sv
// Randomized self-checking bench for vr_stall_injector against a timestamp-based transaction model.
// Expected statistics follow VR_STALL_INJ_STATS_EN when it is defined for the build.
module tb_vr_stall_injector;

    localparam int          DATA_W = 64;
    localparam int          DLY_W  = 4;
    localparam logic [15:0] SEED   = 16'hACE1;
`ifdef VR_STALL_INJ_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush_i = 1'b0;
    logic [1:0]        mode_i = 2'b00;
    logic [DLY_W-1:0]  issue_dly_i = '0;
    logic [DLY_W-1:0]  gap_dly_i = '0;
    logic              up_valid_i = 1'b0;
    logic              up_ready_o;
    logic [DATA_W-1:0] up_data_i = '0;
    logic              dn_valid_o;
    logic              dn_ready_i = 1'b0;
    logic [DATA_W-1:0] dn_data_o;
    logic [31:0]       txn_cnt_o;
    logic [31:0]       stall_cnt_o;

    vr_stall_injector #(.DATA_W(DATA_W), .DLY_W(DLY_W), .LFSR_SEED(SEED)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i), .mode_i(mode_i),
        .issue_dly_i(issue_dly_i), .gap_dly_i(gap_dly_i),
        .up_valid_i(up_valid_i), .up_ready_o(up_ready_o), .up_data_i(up_data_i),
        .dn_valid_o(dn_valid_o), .dn_ready_i(dn_ready_i), .dn_data_o(dn_data_o),
        .txn_cnt_o(txn_cnt_o), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: an accepted entry becomes visible at valid_at; after delivery or flush the
    // upstream side reopens at free_at. Delays come from the spec's LFSR sequence.
    int          cyc = 0;
    int          free_at = 0;
    int          valid_at = 0;
    bit          pending = 1'b0;
    logic [63:0] pend_data = '0;
    logic [15:0] lfsr_m = SEED;
    int          m_txn = 0;
    int          m_stall = 0;
    logic [63:0] src_q[$];
    int          valid_pct = 100;
    int          ready_pct = 100;
    int          flush_pct = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    function automatic int draw(input logic [1:0] mode, input logic [DLY_W-1:0] val,
                                input logic [DLY_W-1:0] rnd);
        if (mode == 2'b00) return 0;
        if (mode == 2'b01) return int'(val);
        return int'(rnd & val);
    endfunction

    task automatic model_reset();
        pending = 1'b0;
        free_at = cyc;
        lfsr_m  = SEED;
        m_txn   = 0;
        m_stall = 0;
        src_q.delete();
    endtask

    task automatic drive();
        up_valid_i = (src_q.size() != 0) && (int'($urandom_range(99)) < valid_pct);
        up_data_i  = (src_q.size() != 0) ? src_q[0] : {$urandom, $urandom};
        dn_ready_i = int'($urandom_range(99)) < ready_pct;
        flush_i    = int'($urandom_range(99)) < flush_pct;
    endtask

    // One clock cycle: compare outputs mid-cycle, advance the model, return just after the edge.
    task automatic tick();
        bit exp_rdy, exp_vld, up_hs, dn_hs;
        @(negedge clk);
        exp_rdy = !flush_i && !pending && (cyc >= free_at);
        exp_vld = pending && (cyc >= valid_at);
        check("up_ready", 64'(up_ready_o), 64'(exp_rdy));
        check("dn_valid", 64'(dn_valid_o), 64'(exp_vld));
        if (exp_vld) check("dn_data", dn_data_o, pend_data);
        if ((pending && cyc < valid_at) || (!pending && cyc < free_at)) m_stall++;
        up_hs = up_valid_i && exp_rdy;
        dn_hs = exp_vld && dn_ready_i;
        if (dn_hs) begin
            m_txn++;
            pending = 1'b0;
            free_at = cyc + draw(mode_i, gap_dly_i, lfsr_m[2*DLY_W-1:DLY_W]) + 1;
        end
        if (flush_i) begin
            pending = 1'b0;
            free_at = cyc + 1;
        end
        if (up_hs) begin
            pending   = 1'b1;
            pend_data = up_data_i;
            valid_at  = cyc + draw(mode_i, issue_dly_i, lfsr_m[DLY_W-1:0]) + 1;
            void'(src_q.pop_front());
        end
        @(posedge clk);
        #1;
        lfsr_m = lfsr_next(lfsr_m);
        cyc++;
    endtask

    task automatic run_items(input string tag, input int budget);
        int b = budget;
        while ((src_q.size() != 0 || pending || cyc < free_at) && b > 0) begin
            drive();
            tick();
            b--;
        end
        check({tag, "_drained"}, 64'(src_q.size() + int'(pending)), 64'd0);
    endtask

    task automatic wait_accept(input int budget);
        int b = budget;
        while (src_q.size() != 0 && b > 0) begin
            drive();
            tick();
            b--;
        end
        check("accept", 64'(src_q.size()), 64'd0);
    endtask

    task automatic check_stats(input string tag);
        check({tag, "_txn"}, 64'(txn_cnt_o), STATS ? 64'(m_txn) : 64'd0);
        check({tag, "_stall"}, 64'(stall_cnt_o), STATS ? 64'(m_stall) : 64'd0);
    endtask

    task automatic set_mode(input logic [1:0] m, input logic [DLY_W-1:0] idly,
                            input logic [DLY_W-1:0] gdly, input int vp, input int rp, input int fp);
        mode_i = m; issue_dly_i = idly; gap_dly_i = gdly;
        valid_pct = vp; ready_pct = rp; flush_pct = fp;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_up_ready", 64'(up_ready_o), 64'd1);
        check("rst_dn_valid", 64'(dn_valid_o), 64'd0);
        check("rst_dn_data", dn_data_o, 64'd0);
        check("rst_txn", 64'(txn_cnt_o), 64'd0);
        check("rst_stall", 64'(stall_cnt_o), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        // Mode 00: back-to-back items, one every 2 cycles
        set_mode(2'b00, 4'h0, 4'h0, 100, 100, 0);
        src_q = '{64'h1, 64'h2, 64'h3};
        run_items("zero", 100);
        check_stats("zero");

        // Mode 01: fixed issue 3 / gap 2
        set_mode(2'b01, 4'h3, 4'h2, 100, 100, 0);
        src_q.push_back(64'hDEAD);
        run_items("fixed", 100);
        check_stats("fixed");

        // Random delays, random consumer backpressure
        set_mode(2'b10, 4'hF, 4'hF, 80, 50, 0);
        for (int i = 0; i < 1000; i++) src_q.push_back({$urandom, $urandom});
        run_items("rand", 60000);
        check_stats("rand");

        // Random delays with random flushes
        set_mode(2'b11, 4'hF, 4'h7, 70, 60, 5);
        for (int i = 0; i < 150; i++) src_q.push_back({$urandom, $urandom});
        run_items("rand_flush", 20000);
        flush_i = 1'b0;
        check_stats("rand_flush");

        // Flush in HOLD: entry dropped, next item normal
        set_mode(2'b01, 4'h5, 4'h0, 100, 100, 0);
        src_q.push_back(64'hF1F1_0000_0000_0001);
        wait_accept(50);
        drive(); tick();
        drive(); flush_i = 1'b1; tick();
        flush_i = 1'b0;
        src_q.push_back(64'hF2F2_0000_0000_0002);
        run_items("flush_hold", 100);
        check_stats("flush_hold");

        // Flush in SEND with dn_ready: still delivered
        set_mode(2'b00, 4'h0, 4'h0, 100, 100, 0);
        src_q.push_back(64'hF3F3_0000_0000_0003);
        wait_accept(50);
        drive(); flush_i = 1'b1; dn_ready_i = 1'b1; tick();
        flush_i = 1'b0;
        run_items("flush_send", 50);
        check_stats("flush_send");

        // Asynchronous reset in SEND
        src_q.push_back(64'hBEEF);
        wait_accept(50);
        up_valid_i = 1'b0; dn_ready_i = 1'b0; flush_i = 1'b0;
        #1;
        check("pre_rst_valid", 64'(dn_valid_o), 64'd1);
        #1;
        rst = 1'b1;
        #1;
        check("arst_dn_valid", 64'(dn_valid_o), 64'd0);
        check("arst_up_ready", 64'(up_ready_o), 64'd1);
        check("arst_dn_data", dn_data_o, 64'd0);
        check("arst_txn", 64'(txn_cnt_o), 64'd0);
        check("arst_stall", 64'(stall_cnt_o), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        // Statistics: 10 items, issue 2, gap 1
        set_mode(2'b01, 4'h2, 4'h1, 100, 100, 0);
        for (int i = 0; i < 10; i++) src_q.push_back(64'(i + 100));
        run_items("stats", 200);
        check_stats("stats");
        check("stats_txn10", 64'(txn_cnt_o), STATS ? 64'd10 : 64'd0);
        check("stats_stall30", 64'(stall_cnt_o), STATS ? 64'd30 : 64'd0);

        // Random delays after reset confirm the LFSR restarted from its seed
        set_mode(2'b10, 4'hF, 4'hF, 90, 70, 0);
        for (int i = 0; i < 50; i++) src_q.push_back({$urandom, $urandom});
        run_items("post_rst", 5000);
        check_stats("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
